median_border_restore: RTL and testbench

//  Sits directly downstream of the 5x5 median stage; consumes its median_o/done_o pixel stream.
//  The 5x5 window yields only (ROWS-4)x(COLS-4) interior pixels; this block restores a full ROWS x COLS raster.

---
 rtl/median_border_pkg.sv | 19 +
 rtl/median_border_restore_fifo.sv | 57 +++++
 rtl/median_border_restore.sv | 151 +++++++++++++++
 tb/tb_median_border_restore.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_border_pkg.sv
// Shared types and constants for the 5x5 median border-restore stage.
package median_border_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Half-width of the 5x5 window, i.e. the width of the border ring.
    localparam int BORDER_W = 2;
    localparam int PIX_W    = 8;

    // Pointer width: one address bit per power of two plus a wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/median_border_restore_fifo.sv
// Pixel FIFO for interior medians; head is readable combinationally from the cycle after a write.
module median_pix_fifo
    import median_border_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] din,
    input  logic             rd_en,
    output logic [PIX_W-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PIX_W-1:0] mem_q [DEPTH];
    logic             do_wr;
    logic             do_rd;

    // Same address with differing wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers alone define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/median_border_restore.sv
// Rebuilds a full ROWS x COLS raster around the 5x5 median interior, filling the ring with BORDER_VAL.
// Optional frame counter output frame_cnt_o is enabled by defining MEDIAN_BORDER_FRAME_CNT_EN.
module median_border_restore
    import median_border_pkg::*;
#(
    parameter int               ROWS       = 7,
    parameter int               COLS       = 7,
    parameter int               FIFO_DEPTH = 16,
    parameter logic [PIX_W-1:0] BORDER_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] median_i,
    input  logic             done_i,
    output logic [PIX_W-1:0] pixel_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             frame_done_o,
    output logic             ovf_o
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt_o
`endif
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_t           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             ovf_q, ovf_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [PIX_W-1:0] fifo_head;
    logic             fifo_pop;
    logic             push;
    logic             interior;
    logic             xfer;

    median_pix_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (done_i),
        .din   (median_i),
        .rd_en (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Full is the pre-read view, so a write into a full FIFO is lost even if a pop happens this cycle.
    assign push  = done_i && !fifo_full;
    assign ovf_d = ovf_q || (done_i && fifo_full);
    assign ovf_o = ovf_q;

    assign interior = (row_q >= RW'(BORDER_W)) && (row_q <= RW'(ROWS - 1 - BORDER_W)) &&
                      (col_q >= CW'(BORDER_W)) && (col_q <= CW'(COLS - 1 - BORDER_W));

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        valid_o      = 1'b0;
        pixel_o      = '0;
        frame_done_o = 1'b0;
        fifo_pop     = 1'b0;
        xfer         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (push || !fifo_empty) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (interior) begin
                    valid_o = !fifo_empty;
                    pixel_o = fifo_empty ? '0 : fifo_head;
                end else begin
                    valid_o = 1'b1;
                    pixel_o = BORDER_VAL;
                end

                xfer     = valid_o && ready_i;
                fifo_pop = xfer && interior;

                if (xfer) begin
                    if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        if (row_q == RW'(ROWS - 1)) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            DONE: begin
                frame_done_o = 1'b1;
                row_d        = '0;
                col_d        = '0;
                // A pixel arriving this very cycle already belongs to the next frame.
                state_d      = (push || !fifo_empty) ? RUN : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef MEDIAN_BORDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    assign frame_cnt_d = frame_cnt_q + 16'(frame_done_o);
    assign frame_cnt_o = frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_median_border_restore.sv
// Self-checking bench for median_border_restore: directed frames, overflow, reset abort, random frames.
module tb_median_border_restore;

    localparam int         ROWS = 7;
    localparam int         COLS = 7;
    localparam int         NPIX = ROWS * COLS;
    localparam logic [7:0] BVAL = 8'd0;

    typedef logic [7:0] pix_q_t[$];
    typedef struct {
        int         row;
        int         col;
        logic [7:0] exp_pix;
    } spot_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] median_i = 8'd0;
    logic       done_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [7:0] pixel_o, pixel2_o;
    logic       valid_o, valid2_o;
    logic       fd_o, fd2_o;
    logic       ovf_o, ovf2_o;
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_o, frame_cnt2_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int fd_cnt = 0;

    pix_q_t     cap, cap2, fed_q, exp_q;
    int         xfer_e[$], done_e[$], fd_e[$];
    logic       stall_prev = 1'b0;
    logic [7:0] prev_pix = 8'd0;
    spot_t      spots[13];

    always #5 clk = ~clk;

    median_border_restore #(
        .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(16), .BORDER_VAL(BVAL)
    ) dut (
        .clk(clk), .rst(rst), .median_i(median_i), .done_i(done_i),
        .pixel_o(pixel_o), .valid_o(valid_o), .ready_i(ready_i),
        .frame_done_o(fd_o), .ovf_o(ovf_o)
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
        , .frame_cnt_o(frame_cnt_o)
`endif
    );

    median_border_restore #(
        .ROWS(ROWS), .COLS(COLS), .FIFO_DEPTH(2), .BORDER_VAL(BVAL)
    ) dut2 (
        .clk(clk), .rst(rst), .median_i(median_i), .done_i(done_i),
        .pixel_o(pixel2_o), .valid_o(valid2_o), .ready_i(ready_i),
        .frame_done_o(fd2_o), .ovf_o(ovf2_o)
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
        , .frame_cnt_o(frame_cnt2_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pix_q_t seq(input int base, input int n);
        pix_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(base + i));
        return q;
    endfunction

    function automatic bit is_interior(input int r, input int c);
        return (r >= 2) && (r <= ROWS - 3) && (c >= 2) && (c <= COLS - 3);
    endfunction

    task automatic clear_state();
        cap.delete(); cap2.delete(); fed_q.delete(); exp_q.delete();
        xfer_e.delete(); done_e.delete(); fd_e.delete();
        fd_cnt = 0;
    endtask

    task automatic do_reset();
        done_i = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_state();
    endtask

    task automatic set_ready_mode(input int m);
        rdy_mode = m;
        case (m)
            2:       ready_i = 1'($urandom_range(1, 0));
            3:       ready_i = 1'b0;
            default: ready_i = 1'b1;
        endcase
    endtask

    task automatic feed(input pix_q_t vals, input int gap_min, input int gap_max);
        foreach (vals[i]) begin
            done_i   = 1'b1;
            median_i = vals[i];
            fed_q.push_back(vals[i]);
            tick();
            done_i = 1'b0;
            repeat (int'($urandom_range(gap_max, gap_min)) - 1) tick();
        end
    endtask

    task automatic wait_xfer(input int n, input int budget);
        for (int k = 0; k < budget && cap.size() < n; k++) tick();
    endtask

    // Reference raster: ring positions carry BVAL, interior positions take fed pixels in raster order.
    task automatic build_expected();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (is_interior(r, c) && fed_q.size() > 0) exp_q.push_back(fed_q.pop_front());
                else exp_q.push_back(BVAL);
    endtask

    task automatic compare_raster(input string tag);
        check({tag, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            check($sformatf("%s_pix[%0d]", tag, i), 32'(cap[i]), 32'(exp_q[i]));
    endtask

    // With ready held high, each pixel moves one cycle after its predecessor, and an interior
    // pixel additionally no earlier than the cycle after its done_i.
    task automatic check_timing(input string tag);
        int t;
        int j;
        bit ok;
        t = 0;
        j = 0;
        ok = (xfer_e.size() >= NPIX) && (done_e.size() >= 9);
        check({tag, "_timing_data"}, 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < NPIX; i++) begin
                t = (i == 0) ? done_e[0] + 1 : t + 1;
                if (is_interior(i / COLS, i % COLS)) begin
                    if (done_e[j] + 1 > t) t = done_e[j] + 1;
                    j++;
                end
                check($sformatf("%s_edge[%0d]", tag, i), 32'(xfer_e[i]), 32'(t));
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       ready_i = ~ready_i;
            2:       ready_i = 1'($urandom_range(1, 0));
            3:       ready_i = 1'b0;
            default: ready_i = 1'b1;
        endcase
    end

    // Negedge monitor: records transfers and checks that a stalled output holds.
    initial forever begin
        @(negedge clk);
        if (rst && done_i) done_e.push_back(cyc + 1);
        if (rst && valid_o && ready_i) begin
            cap.push_back(pixel_o);
            xfer_e.push_back(cyc + 1);
        end
        if (rst && valid2_o && ready_i) cap2.push_back(pixel2_o);
        if (rst && fd_o) begin
            fd_cnt++;
            fd_e.push_back(cyc);
        end
        if (stall_prev && rst) begin
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_pixel", 32'(pixel_o), 32'(prev_pix));
        end
        stall_prev = rst && valid_o && !ready_i;
        prev_pix   = pixel_o;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        pix_q_t rv;

        spots[0]  = '{0, 0, 8'd0};
        spots[1]  = '{1, 3, 8'd0};
        spots[2]  = '{2, 1, 8'd0};
        spots[3]  = '{2, 2, 8'd10};
        spots[4]  = '{2, 3, 8'd11};
        spots[5]  = '{2, 4, 8'd12};
        spots[6]  = '{2, 5, 8'd0};
        spots[7]  = '{3, 2, 8'd13};
        spots[8]  = '{3, 4, 8'd15};
        spots[9]  = '{4, 2, 8'd16};
        spots[10] = '{4, 4, 8'd18};
        spots[11] = '{5, 3, 8'd0};
        spots[12] = '{6, 6, 8'd0};

        set_ready_mode(0);
        repeat (2) tick();
        do_reset();

        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_pixel", 32'(pixel_o), 32'd0);
        check("rst_frame_done", 32'(fd_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_valid2", 32'(valid2_o), 32'd0);
        check("rst_ovf2", 32'(ovf2_o), 32'd0);
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
        check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
`endif

        // Single frame, consecutive pixels, always ready.
        feed(seq(10, 9), 1, 1);
        wait_xfer(NPIX, 200);
        repeat (3) tick();
        for (int i = 0; i < 13; i++)
            check($sformatf("t1_spot_r%0d_c%0d", spots[i].row, spots[i].col),
                  (spots[i].row * COLS + spots[i].col < cap.size()) ?
                      32'(cap[spots[i].row * COLS + spots[i].col]) : 32'hFFFF_FFFF,
                  32'(spots[i].exp_pix));
        build_expected();
        compare_raster("t1");
        check_timing("t1");
        check("t1_fd_count", 32'(fd_cnt), 32'd1);
        if (fd_e.size() > 0 && xfer_e.size() >= NPIX)
            check("t1_fd_edge", 32'(fd_e[0]), 32'(xfer_e[NPIX-1]));
        check("t1_ovf", 32'(ovf_o), 32'd0);

        // Same frame with ready toggling every cycle.
        do_reset();
        set_ready_mode(1);
        feed(seq(10, 9), 1, 1);
        wait_xfer(NPIX, 400);
        repeat (3) tick();
        build_expected();
        compare_raster("t2");
        check("t2_fd_count", 32'(fd_cnt), 32'd1);
        check("t2_ovf", 32'(ovf_o), 32'd0);

        // Sparse input: borders flow freely, interior positions wait for data.
        do_reset();
        set_ready_mode(0);
        feed(seq(10, 9), 20, 20);
        wait_xfer(NPIX, 400);
        repeat (3) tick();
        build_expected();
        compare_raster("t3");
        check_timing("t3");

        // Overflow on the depth-2 instance while the output is blocked.
        do_reset();
        set_ready_mode(3);
        feed(seq(1, 3), 1, 1);
        tick();
        check("t4_ovf2", 32'(ovf2_o), 32'd1);
        check("t4_ovf_deep", 32'(ovf_o), 32'd0);
        check("t4_no_xfer", 32'(cap2.size()), 32'd0);
        set_ready_mode(0);
        repeat (40) tick();
        check("t4_xfer_count", 32'(cap2.size()), 32'd18);
        if (cap2.size() >= 18) begin
            check("t4_border15", 32'(cap2[15]), 32'(BVAL));
            check("t4_int0", 32'(cap2[16]), 32'd1);
            check("t4_int1", 32'(cap2[17]), 32'd2);
        end
        check("t4_stall_valid", 32'(valid2_o), 32'd0);
        check("t4_ovf2_sticky", 32'(ovf2_o), 32'd1);

        // Two frames back to back.
        do_reset();
        set_ready_mode(0);
        feed(seq(0, 18), 2, 2);
        wait_xfer(2 * NPIX, 400);
        repeat (3) tick();
        build_expected();
        build_expected();
        compare_raster("t5");
        check("t5_fd_count", 32'(fd_cnt), 32'd2);
        check("t5_ovf", 32'(ovf_o), 32'd0);
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
        check("t5_frame_cnt", 32'(frame_cnt_o), 32'd2);
`endif

        // Reset mid-frame, then a fresh frame.
        do_reset();
        set_ready_mode(0);
        feed(seq(10, 9), 1, 1);
        wait_xfer(20, 200);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t6_rst_valid", 32'(valid_o), 32'd0);
        check("t6_rst_pixel", 32'(pixel_o), 32'd0);
        check("t6_rst_frame_done", 32'(fd_o), 32'd0);
        check("t6_rst_ovf", 32'(ovf_o), 32'd0);
`ifdef MEDIAN_BORDER_FRAME_CNT_EN
        check("t6_rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
`endif
        clear_state();
        repeat (5) tick();
        check("t6_idle_valid", 32'(valid_o), 32'd0);
        check("t6_idle_no_xfer", 32'(cap.size()), 32'd0);
        feed(seq(10, 9), 1, 1);
        wait_xfer(NPIX, 200);
        repeat (3) tick();
        build_expected();
        compare_raster("t6");
        check_timing("t6");
        check("t6_fd_count", 32'(fd_cnt), 32'd1);

        // Random pixel values, gaps and backpressure over three frames.
        do_reset();
        set_ready_mode(2);
        for (int k = 0; k < 3; k++) begin
            rv.delete();
            for (int i = 0; i < 9; i++) rv.push_back(8'($urandom_range(255, 0)));
            feed(rv, 1, 4);
            wait_xfer(NPIX * (k + 1), 600);
            build_expected();
        end
        repeat (3) tick();
        compare_raster("rnd");
        check("rnd_fd_count", 32'(fd_cnt), 32'd3);
        check("rnd_ovf", 32'(ovf_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
